spi_ram_arbiter: RTL
====================

Name: spi_ram_arbiter

Overview:
- Two-requester controller that shares the single-port SPI RAM between requesters, e.g. the SPI slave front-end and a host/DMA port.
- Accepts simple word-level read/write requests.
- Serializes each request into the RAM's 10-bit command protocol:
  - 00 = write address
  - 01 = write data
  - 10 = read address
  - 11 = read trigger
- Returns read data to the owning requester.
- Round-robin arbitration with a read-response timeout.

Parameters:
ADDR_W, 8, RAM address width; RAM command word is ADDR_W+2 bits
TIMEOUT, 16, max cycles waited in RD_WAIT for ram_tx_valid before flagging error
DUMMY, 8'hFF, payload sent with the 11 read-trigger command

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
req_i  in  2  per-requester request; held high until the matching gnt_o bit
we_i  in  2  per-requester op: 1 = write, 0 = read
addr_i  in  2*ADDR_W  requester 0 in [ADDR_W-1:0], requester 1 in upper half
wdata_i  in  16  requester 0 in [7:0], requester 1 in [15:8]
gnt_o  out  2  one-cycle pulse: request latched, requester may change inputs
done_o  out  2  one-cycle pulse: transaction complete for that requester
rdata_o  out  8  read data; valid while done_o is high for a read
err_o  out  1  high with done_o when a read timed out
ram_din  out  ADDR_W+2  command word to RAM
ram_rx_valid  out  1  qualifies ram_din
ram_dout  in  8  RAM read data
ram_tx_valid  in  1  RAM read data valid

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - gnt_o, done_o, err_o, ram_rx_valid = 0; rdata_o=0; ram_din=0.
  - last=1, so requester 0 wins the first tie.
  - Reset mid-transaction aborts it silently: no done_o, RAM command stream stops immediately.
- All outputs registered; state-driven outputs are decoded from the registered state/owner.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, DONE.
- IDLE:
  - No req: stay in IDLE, ram_rx_valid=0.
  - Any req: pick owner.
    - Single req: that requester.
    - Both req: requester != last.
  - Latch we/addr/wdata of owner.
  - Go to WR_ADDR (we=1) or RD_ADDR (we=0).
- WR_ADDR: gnt_o[owner]=1, ram_rx_valid=1, ram_din={2'b00,addr} -> WR_DATA.
- WR_DATA: ram_rx_valid=1, ram_din={2'b01,wdata} -> DONE.
- RD_ADDR: gnt_o[owner]=1, ram_rx_valid=1, ram_din={2'b10,addr} -> RD_CMD.
- RD_CMD: ram_rx_valid=1, ram_din={2'b11,DUMMY}; clear timeout counter -> RD_WAIT.
- RD_WAIT: ram_rx_valid=0.
  - ram_tx_valid=1: rdata reg <= ram_dout, err <= 0 -> DONE.
  - Else counter++; at counter==TIMEOUT-1: rdata reg <= 0, err <= 1 -> DONE.
- DONE: done_o[owner]=1, rdata_o/err_o presented (err_o=0 for writes); last<=owner -> IDLE.
- ram_tx_valid outside RD_WAIT is ignored.
- Latency, counted from the posedge that samples req in IDLE:
  - gnt_o next cycle.
  - Write: done_o 3 cycles later.
  - Read with RAM answering in the first RD_WAIT cycle: done_o 4 cycles later.
- Back-to-back: no new request accepted in DONE. Minimum one IDLE cycle between transactions, so the write throughput bound is 4 cycles/op.
- req deasserted before gnt: withdrawn if sampled low in IDLE. After gnt, req is don't-care until done.
- Fairness: with both req held continuously, grants strictly alternate 0,1,0,1.
- Counter width $clog2(TIMEOUT+1); saturates, never wraps.

Test Plan:
- Reset then single write: req_i=01, we=1, addr0=8'h3C, wdata0=8'hA5 -> ram_din 0x03C then 0x1A5 with ram_rx_valid=1 on consecutive cycles; gnt_o=01 one cycle; done_o=01 three cycles after sample; err_o=0.
- Read-back via RAM model: req1 read addr 8'h3C -> ram_din 0x23C then 0x3FF; tx_valid returned -> done_o=10, rdata_o=8'hA5, err_o=0.
- Contention: both req held for 8 transactions after reset -> grant order 0,1,0,1,...; every ram_din pair stays contiguous, never interleaved between requesters.
- Timeout: RAM model never asserts tx_valid on a read -> done_o after exactly TIMEOUT RD_WAIT cycles, err_o=1, rdata_o=0; next write completes normally with err_o=0.
- Reset mid-op: assert rst_n=0 during WR_DATA -> all outputs 0 immediately; no done_o; first post-reset tie grants requester 0.
- Sweep: 256 random writes from alternating requesters, then reads of all addresses -> every rdata_o matches a scoreboard keyed by address (last write wins).

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Shares one single-port SPI RAM between two word-level requesters.
//   Each request becomes a short stream of command words on the RAM's
//   (ADDR_W+2)-bit command port:
//     00 = write address, 01 = write data, 10 = read address, 11 = read trigger.
//   Arbitration is round-robin. A read whose data does not come back within
//   TIMEOUT cycles completes with err_o set and rdata_o = 0.
//
// Ports
//   clk, rst_n     system clock (posedge) and asynchronous active-low reset
//   req_i[1:0]     per-requester request, held until the matching gnt_o bit
//   we_i[1:0]      per-requester operation: 1 = write, 0 = read
//   addr_i         requester 0 in [ADDR_W-1:0], requester 1 in the upper half
//   wdata_i[15:0]  requester 0 in [7:0], requester 1 in [15:8]
//   gnt_o[1:0]     one-cycle pulse: request latched, inputs may change
//   done_o[1:0]    one-cycle pulse: transaction complete
//   rdata_o[7:0]   read data, valid while done_o is high for a read
//   err_o          read timed out, valid with done_o
//   ram_din        command word to the RAM, qualified by ram_rx_valid
//   ram_dout       RAM read data, qualified by ram_tx_valid

module spi_ram_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter logic [7:0]  DUMMY   = 8'hFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_i,
    input  logic [1:0]          we_i,
    input  logic [2*ADDR_W-1:0] addr_i,
    input  logic [15:0]         wdata_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          done_o,
    output logic [7:0]          rdata_o,
    output logic                err_o,
    output logic [ADDR_W+1:0]   ram_din,
    output logic                ram_rx_valid,
    input  logic [7:0]          ram_dout,
    input  logic                ram_tx_valid
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_CMD,
        RD_WAIT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]        gnt_d;
    logic [1:0]        done_d;
    logic [7:0]        rdata_d;
    logic              err_d;
    logic [ADDR_W+1:0] ram_din_d;
    logic              ram_rx_valid_d;

    // Requester selection for a new transaction; only consumed in IDLE.
    logic              pick;
    logic [ADDR_W-1:0] pick_addr;
    logic [7:0]        pick_wdata;
    logic              pick_we;

    always_comb begin
        pick = 1'b0;
        if (req_i == 2'b11) begin
            // Tie: whoever was not served last goes next.
            pick = ~last_q;
        end else begin
            pick = req_i[1];
        end
        pick_addr  = pick ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
        pick_wdata = pick ? wdata_i[15:8] : wdata_i[7:0];
        pick_we    = we_i[pick];
    end

    // Registered outputs are loaded from the decode of the state being
    // entered, so each output is valid during the state it belongs to.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        gnt_d          = '0;
        done_d         = '0;
        rdata_d        = '0;
        err_d          = 1'b0;
        ram_din_d      = '0;
        ram_rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    owner_d        = pick;
                    wdata_d        = pick_wdata;
                    gnt_d[pick]    = 1'b1;
                    ram_rx_valid_d = 1'b1;
                    if (pick_we) begin
                        state_d   = WR_ADDR;
                        ram_din_d = {2'b00, pick_addr};
                    end else begin
                        state_d   = RD_ADDR;
                        ram_din_d = {2'b10, pick_addr};
                    end
                end
            end

            WR_ADDR: begin
                state_d        = WR_DATA;
                ram_rx_valid_d = 1'b1;
                ram_din_d      = {2'b01, ADDR_W'(wdata_q)};
            end

            WR_DATA: begin
                state_d         = DONE;
                done_d[owner_q] = 1'b1;
            end

            RD_ADDR: begin
                state_d        = RD_CMD;
                ram_rx_valid_d = 1'b1;
                ram_din_d      = {2'b11, ADDR_W'(DUMMY)};
            end

            RD_CMD: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end

            RD_WAIT: begin
                if (ram_tx_valid) begin
                    state_d         = DONE;
                    done_d[owner_q] = 1'b1;
                    rdata_d         = ram_dout;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = DONE;
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                last_d  = owner_q;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            wdata_q      <= '0;
            cnt_q        <= '0;
            gnt_o        <= '0;
            done_o       <= '0;
            rdata_o      <= '0;
            err_o        <= 1'b0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            gnt_o        <= gnt_d;
            done_o       <= done_d;
            rdata_o      <= rdata_d;
            err_o        <= err_d;
            ram_din      <= ram_din_d;
            ram_rx_valid <= ram_rx_valid_d;
        end
    end

endmodule
